// File: rtl/input_conditioner_if.sv
// Pin-side and PIO-side signal bundle for the input conditioner.
// The slave modport is the conditioner; the master modport is the board/test side.
interface input_conditioner_if #(
  parameter int unsigned NUM_BUTTONS  = 2,
  parameter int unsigned NUM_SWITCHES = 10
);
  logic [NUM_BUTTONS-1:0]  key_n_in;
  logic [NUM_SWITCHES-1:0] sw_in;
  logic [NUM_BUTTONS-1:0]  buttons_export;
  logic [NUM_SWITCHES-1:0] switches_export;
  logic [NUM_BUTTONS-1:0]  button_press;
  logic [NUM_BUTTONS-1:0]  button_release;

  modport slave (
    input  key_n_in,
    input  sw_in,
    output buttons_export,
    output switches_export,
    output button_press,
    output button_release
  );

  modport master (
    output key_n_in,
    output sw_in,
    input  buttons_export,
    input  switches_export,
    input  button_press,
    input  button_release
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces KEY/SW pins, emits button press/release pulses.
// Define INPUT_CONDITIONER_AUTO_REPEAT_EN to add held-button auto-repeat press pulses.
module input_conditioner #(
  parameter int unsigned NUM_BUTTONS          = 2,
  parameter int unsigned NUM_SWITCHES         = 10,
  parameter int unsigned DEBOUNCE_CYCLES      = 1000000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 5000000
) (
  input logic                clk_clk,
  input logic                reset_reset_n,
  input_conditioner_if.slave pins
);

  localparam int unsigned NumIn = NUM_BUTTONS + NUM_SWITCHES;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1)
  begin : gen_param_check
    $error("input_conditioner: invalid cycle-count parameters");
  end

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                   REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned RptW   = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] RptDelayLast  = RptW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RptW-1:0] RptPeriodLast = RptW'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {StReleased, StPressed, StRepeatWait, StRepeating} btn_state_e;
`else
  typedef enum logic [0:0] {StReleased, StPressed} btn_state_e;
`endif

  // Two-flop synchronisers; buttons idle high (released) on the pin.
  logic [NUM_BUTTONS-1:0]  key_sync1_q, key_sync2_q;
  logic [NUM_SWITCHES-1:0] sw_sync1_q, sw_sync2_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_sync1_q <= '1;
      key_sync2_q <= '1;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
    end else begin
      key_sync1_q <= pins.key_n_in;
      key_sync2_q <= key_sync1_q;
      sw_sync1_q  <= pins.sw_in;
      sw_sync2_q  <= sw_sync1_q;
    end
  end

  // Buttons occupy the low bits of every per-input vector, switches the high bits.
  logic [NumIn-1:0] raw;
  logic [NumIn-1:0] stable_q, stable_d;
  logic [NumIn-1:0] accept;
  logic [DbW-1:0]   db_cnt_q [NumIn];
  logic [DbW-1:0]   db_cnt_d [NumIn];

  assign raw = {sw_sync2_q, ~key_sync2_q};

  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < NumIn; i++) begin
      db_cnt_d[i] = '0;
      if (raw[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = raw[i];
          accept[i]   = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_q <= '0;
      db_cnt_q <= '{default: '0};
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Per-button state machine; pulses are registered alongside the stable level.
  btn_state_e             state_q [NUM_BUTTONS];
  btn_state_e             state_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
  logic [RptW-1:0]        rpt_cnt_q [NUM_BUTTONS];
  logic [RptW-1:0]        rpt_cnt_d [NUM_BUTTONS];
`endif

  always_comb begin
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i] = state_q[i];
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
      rpt_cnt_d[i] = '0;
`endif
      if (state_q[i] == StReleased) begin
        if (accept[i]) begin
          state_d[i] = StPressed;
          press_d[i] = 1'b1;
        end
      end else if (accept[i]) begin
        // Release wins over any repeat pulse due in the same cycle.
        state_d[i]   = StReleased;
        release_d[i] = 1'b1;
      end
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
      else begin
        case (state_q[i])
          StPressed, StRepeatWait: begin
            if (rpt_cnt_q[i] == RptDelayLast) begin
              state_d[i] = StRepeating;
              press_d[i] = 1'b1;
            end else begin
              state_d[i]   = StRepeatWait;
              rpt_cnt_d[i] = rpt_cnt_q[i] + RptW'(1);
            end
          end
          StRepeating: begin
            if (rpt_cnt_q[i] == RptPeriodLast) begin
              press_d[i] = 1'b1;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RptW'(1);
            end
          end
          default: state_d[i] = StReleased;
        endcase
      end
`endif
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= '{default: StReleased};
      press_q   <= '0;
      release_q <= '0;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
      rpt_cnt_q <= '{default: '0};
`endif
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
`endif
    end
  end

  assign pins.buttons_export  = stable_q[NUM_BUTTONS-1:0];
  assign pins.switches_export = stable_q[NumIn-1:NUM_BUTTONS];
  assign pins.button_press    = press_q;
  assign pins.button_release  = release_q;

endmodule
